unsigned_approx_div_16by8_l4: RTL

Sequential unsigned 16÷8 restoring divider. It is the inverse companion of the approximate 8x8 multipliers in the unsigned 8b library: it recovers an 8-bit quotient from a 16-bit product and an 8-bit operand. Like the l=4 multipliers, it skips the L least-significant quotient bits: those bits are not computed and are forced to zero, trading accuracy for latency. A valid/ready handshake sits on both sides, so it drops into error-characterization and datapath benches without glue.

---
 rtl/unsigned_approx_div_16by8_l4.sv | 112 +++++++++++
 1 files changed

// File: rtl/unsigned_approx_div_16by8_l4.sv
// Sequential unsigned 16/8 restoring divider; the L quotient LSBs are skipped and read as zero.
// Define DIV_REM_OUT_EN to expose the remainder on port r.
module unsigned_approx_div_16by8_l4 #(
    parameter int L = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] z,
    input  logic [7:0]  y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  q,
    output logic        ovf
`ifdef DIV_REM_OUT_EN
    ,
    output logic [7:0]  r
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic [2:0] LAST = 3'(L);

    state_t     state;
    logic [7:0] div;
    logic [7:0] zlow;
    logic [7:0] rem;
    logic [2:0] cnt;

    logic [8:0] trial;
    logic       fits;
    logic [7:0] rem_next;

    assign in_ready = (state == IDLE) && !rst;

    // rem < div on entry, so the shifted trial fits in 9 bits and the new remainder fits in 8.
    always_comb begin
        trial    = {rem, zlow[cnt]};
        fits     = trial >= {1'b0, div};
        rem_next = fits ? 8'(trial - {1'b0, div}) : trial[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            q         <= 8'h00;
            ovf       <= 1'b0;
            cnt       <= 3'd0;
            div       <= 8'h00;
            zlow      <= 8'h00;
            rem       <= 8'h00;
`ifdef DIV_REM_OUT_EN
            r         <= 8'h00;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        div  <= y;
                        zlow <= z[7:0];
                        rem  <= z[15:8];
                        // A high byte at or above the divisor means the quotient needs more than 8 bits.
                        if (y == 8'h00 || z[15:8] >= y) begin
                            q         <= 8'hFF;
                            ovf       <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
`ifdef DIV_REM_OUT_EN
                            r         <= 8'h00;
`endif
                        end else begin
                            q     <= 8'h00;
                            ovf   <= 1'b0;
                            cnt   <= 3'd7;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_next;
                    if (fits) begin
                        q[cnt] <= 1'b1;
                    end
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
`ifdef DIV_REM_OUT_EN
                        r         <= rem_next;
`endif
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
